// File: rtl/video_pkg.sv
// Shared video definitions for the palette lookup unit.
//   EGA_ENTRIES  - number of entries that carry EGA power-on defaults
//   EGA_DEFAULT  - the 16 standard EGA rgbRGB colours (6 bits each)
//   colour_sel_e - stage-2 colour source (blank, bypass, table lookup)
//   ega_default  - reset value for any table entry (0 beyond the EGA set)
package video_pkg;

  localparam int EGA_ENTRIES = 16;

  localparam logic [5:0] EGA_DEFAULT [EGA_ENTRIES] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h14, 6'h07,
    6'h38, 6'h39, 6'h3A, 6'h3B, 6'h3C, 6'h3D, 6'h3E, 6'h3F
  };

  typedef enum logic [1:0] {
    BLANK,
    BYPASS,
    LOOKUP
  } colour_sel_e;

  function automatic logic [5:0] ega_default(input int i);
    logic [5:0] value;
    value = '0;
    if (i >= 0 && i < EGA_ENTRIES) value = EGA_DEFAULT[i[3:0]];
    return value;
  endfunction

  // Blanking dominates; bypass shows the raw index; otherwise use the table.
  function automatic colour_sel_e colour_select(input logic blank, input logic enable);
    if (blank)        return BLANK;
    else if (!enable) return BYPASS;
    else              return LOOKUP;
  endfunction

endpackage

// File: rtl/palette_lookup_unit_if.sv
// Bus bundle for the palette lookup unit.
//   pixel side : pixel_valid, pixel_index, pixel_blank, vblank, palette_enable
//   colour side: colour_valid, colour_out
//   cpu write  : wr_valid, wr_ready, wr_index, wr_colour
//   cpu read   : rd_valid, rd_index, rd_data, rd_data_valid
// master = pixel source / CPU side, slave = palette unit.
interface palette_lookup_unit_if #(
  parameter int INDEX_WIDTH  = 4,
  parameter int COLOUR_WIDTH = 6
);
  logic                    pixel_valid;
  logic [INDEX_WIDTH-1:0]  pixel_index;
  logic                    pixel_blank;
  logic                    vblank;
  logic                    palette_enable;
  logic                    colour_valid;
  logic [COLOUR_WIDTH-1:0] colour_out;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [INDEX_WIDTH-1:0]  wr_index;
  logic [COLOUR_WIDTH-1:0] wr_colour;
  logic                    rd_valid;
  logic [INDEX_WIDTH-1:0]  rd_index;
  logic [COLOUR_WIDTH-1:0] rd_data;
  logic                    rd_data_valid;

  modport master (
    output pixel_valid, pixel_index, pixel_blank, vblank, palette_enable,
    output wr_valid, wr_index, wr_colour, rd_valid, rd_index,
    input  colour_valid, colour_out, wr_ready, rd_data, rd_data_valid
  );

  modport slave (
    input  pixel_valid, pixel_index, pixel_blank, vblank, palette_enable,
    input  wr_valid, wr_index, wr_colour, rd_valid, rd_index,
    output colour_valid, colour_out, wr_ready, rd_data, rd_data_valid
  );
endinterface

// File: rtl/palette_table.sv
// Palette register array, 2**INDEX_WIDTH entries of COLOUR_WIDTH bits.
//   clk, rst      - clock, synchronous active-high reset (reloads EGA defaults)
//   wr_en         - write strobe; wr_index/wr_colour written on the edge
//   pix_index     - async read port for the pixel pipeline -> pix_colour
//   rd_index      - async read port for CPU readback      -> rd_colour
// Reads are combinational, so a same-edge write is seen only from the next cycle.
module palette_table
  import video_pkg::*;
#(
  parameter int INDEX_WIDTH  = 4,
  parameter int COLOUR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [COLOUR_WIDTH-1:0] wr_colour,
  input  logic [INDEX_WIDTH-1:0]  pix_index,
  output logic [COLOUR_WIDTH-1:0] pix_colour,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  output logic [COLOUR_WIDTH-1:0] rd_colour
);
  localparam int DEPTH = 2 ** INDEX_WIDTH;

  logic [COLOUR_WIDTH-1:0] mem [DEPTH];

  // NOTE: this array is deliberately reset (defaults must reappear on reset),
  // which forces flops rather than RAM; an array without reset values should
  // not be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= COLOUR_WIDTH'(ega_default(i));
    end else if (wr_en) begin
      mem[wr_index] <= wr_colour;
    end
  end

  assign pix_colour = mem[pix_index];
  assign rd_colour  = mem[rd_index];
endmodule

// File: rtl/palette_lookup_unit.sv
// Programmable colour palette between the pixel-index source and the DAC.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of palette_lookup_unit_if (pixel in, colour out,
//              CPU write handshake, CPU registered readback)
// Pixel path is a fixed two-stage pipeline without back-pressure.
module palette_lookup_unit
  import video_pkg::*;
#(
  parameter int INDEX_WIDTH         = 4,
  parameter int COLOUR_WIDTH        = 6,
  parameter bit WRITE_IN_BLANK_ONLY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  palette_lookup_unit_if.slave  bus
);
  logic                    s1_valid;
  logic [INDEX_WIDTH-1:0]  s1_index;
  logic                    s1_blank;
  logic                    s1_enable;
  logic                    wr_en;
  logic [COLOUR_WIDTH-1:0] pix_colour;
  logic [COLOUR_WIDTH-1:0] rd_colour;
  logic [COLOUR_WIDTH-1:0] colour_next;
  colour_sel_e             sel;

  // Held low during reset so a pending request cannot be seen as accepted.
  assign bus.wr_ready = !rst && (WRITE_IN_BLANK_ONLY ? bus.vblank : 1'b1);
  assign wr_en        = bus.wr_valid && bus.wr_ready;

  palette_table #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .COLOUR_WIDTH(COLOUR_WIDTH)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_index  (bus.wr_index),
    .wr_colour (bus.wr_colour),
    .pix_index (s1_index),
    .pix_colour(pix_colour),
    .rd_index  (bus.rd_index),
    .rd_colour (rd_colour)
  );

  // NOTE: every flop uses <= so all stages sample pre-edge values; blocking
  // assignments here would collapse the two pipeline stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_index  <= '0;
      s1_blank  <= 1'b0;
      s1_enable <= 1'b0;
    end else begin
      s1_valid  <= bus.pixel_valid;
      s1_index  <= bus.pixel_index;
      s1_blank  <= bus.pixel_blank;
      s1_enable <= bus.palette_enable;
    end
  end

  // NOTE: colour_next is assigned before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    colour_next = '0;
    sel         = colour_select(s1_blank, s1_enable);
    unique case (sel)
      BLANK:   colour_next = '0;
      BYPASS:  colour_next = COLOUR_WIDTH'(s1_index);
      LOOKUP:  colour_next = pix_colour;
      default: colour_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.colour_valid  <= 1'b0;
      bus.colour_out    <= '0;
      bus.rd_data_valid <= 1'b0;
      bus.rd_data       <= '0;
    end else begin
      bus.colour_valid  <= s1_valid;
      if (s1_valid) bus.colour_out <= colour_next;
      bus.rd_data_valid <= bus.rd_valid;
      if (bus.rd_valid) bus.rd_data <= rd_colour;
    end
  end
endmodule
